// File: rtl/ps2_kbd_pkg.sv
// Shared types and Set-2 scan-code constants for the PS/2 keyboard decoder.
// Event layout, prefix/LED state encodings and modifier held-bit indices.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } pfx_st_e;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CMD,
    L_WACK1,
    L_DATA,
    L_WACK2
  } led_st_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic       caps;
    logic       num;
    logic       alt;
    logic       ctrl;
    logic       shift;
    logic       rsvd;
    logic [7:0] code;
  } kbd_ev_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_NUM     = 8'h77;
  localparam logic [7:0] SC_SCRL    = 8'h7E;
  localparam logic [7:0] SC_BAT     = 8'hAA;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_RESEND  = 8'hFE;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_ERR0    = 8'h00;
  localparam logic [7:0] SC_ERR1    = 8'hFF;
  localparam logic [7:0] SC_LED     = 8'hED;

  localparam int H_LSHIFT = 0;
  localparam int H_RSHIFT = 1;
  localparam int H_LCTRL  = 2;
  localparam int H_RCTRL  = 3;
  localparam int H_LALT   = 4;
  localparam int H_RALT   = 5;
  localparam int H_CAPS   = 6;
  localparam int H_NUM    = 7;
  localparam int H_SCRL   = 8;

  function automatic logic is_ctl(input logic [7:0] b);
    return b inside {SC_BAT, SC_ACK, SC_RESEND,
                     SC_ECHO, SC_ERR0, SC_ERR1};
  endfunction

endpackage

// File: rtl/ps2_kbd_scan_decoder_fifo.sv
// Event FIFO with a registered head word; a pop and a push may
// share a cycle even when full, the pop freeing the slot first.
module ps2_evt_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int pDepth = 16
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  kbd_ev_t dat_i,
  input  logic    pop_i,
  output logic    valid_o,
  output kbd_ev_t dat_o,
  output logic    drop_o
);

  localparam int AW = $clog2(pDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(pDepth);

  kbd_ev_t         mem_q [pDepth];
  kbd_ev_t         dat_q, dat_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != FULL_C) || pop_ok);
    drop_o  = push_i && !push_ok;
    rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok)
      cnt_d = cnt_q - CW'(1);
    // Head comes from the bypass when the queue drains to empty this cycle.
    dat_d = dat_q;
    if (push_ok && ((cnt_q == '0) ||
        ((cnt_q == CW'(1)) && pop_ok)))
      dat_d = dat_i;
    else if (pop_ok && (cnt_q > CW'(1)))
      dat_d = mem_q[rd_d];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wr_q] <= dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      dat_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign dat_o   = dat_q;

endmodule

// File: rtl/ps2_kbd_scan_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix stripping, modifiers, event FIFO.
// Define KBD_DEC_LOCK_EN for lock-key tracking and the keyboard LED sequencer.
module ps2_kbd_scan_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int pFifoDepth = 16,
  parameter int pPauseLen  = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_perr_i,
  output logic        ev_valid_o,
  output logic [15:0] ev_dat_o,
  input  logic        ev_pop_i,
  input  logic        clr_i,
  output logic        ovf_o,
  output logic        perr_o,
  output logic        bat_o,
  output logic        ack_o,
  output logic        tx_req_o,
  output logic [7:0]  tx_dat_o,
  input  logic        tx_done_i
);

  localparam int PW = $clog2(pPauseLen + 1);

  pfx_st_e       st_q, st_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [8:0]    held_q, held_d;
  logic [2:0]    lock_q, lock_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          bat_q, bat_d;
  logic          ack_q, ack_d;

  logic          ok_stb, fa_v;
  logic          key_v, brk_v, ext_v, push_v;
  logic [2:0]    tgl_v;
  logic [7:0]    code_v;
  kbd_ev_t       ev_v, fifo_dat;
  logic          fifo_drop;
  logic          unused_ok;

  assign ok_stb = rx_stb_i && !rx_perr_i;
  assign fa_v   = ok_stb && (rx_dat_i == SC_ACK);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    held_d = held_q;
    lock_d = lock_q;
    key_v  = 1'b0;
    brk_v  = 1'b0;
    ext_v  = 1'b0;
    push_v = 1'b0;
    tgl_v  = 3'b000;
    code_v = rx_dat_i;
    if (rx_stb_i && rx_perr_i) begin
      st_d = S_IDLE;
    end else if (ok_stb && !is_ctl(rx_dat_i)) begin
      unique case (st_q)
        S_IDLE: begin
          unique case (1'b1)
            rx_dat_i == SC_EXT: st_d = S_EXT;
            rx_dat_i == SC_BRK: st_d = S_BRK;
            rx_dat_i == SC_PAUSE: begin
              st_d  = S_PAUSE;
              cnt_d = PW'(pPauseLen);
            end
            default: key_v = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_dat_i == SC_BRK) begin
            st_d = S_EXT_BRK;
          end else if (rx_dat_i != SC_EXT) begin
            key_v = 1'b1;
            ext_v = 1'b1;
            st_d  = S_IDLE;
          end
        end
        S_BRK: begin
          key_v = 1'b1;
          brk_v = 1'b1;
          st_d  = S_IDLE;
        end
        S_EXT_BRK: begin
          key_v = 1'b1;
          brk_v = 1'b1;
          ext_v = 1'b1;
          st_d  = S_IDLE;
        end
        S_PAUSE: begin
          cnt_d = cnt_q - PW'(1);
          if (cnt_q == PW'(1)) begin
            push_v = 1'b1;
            ext_v  = 1'b1;
            code_v = SC_NUM;
            st_d   = S_IDLE;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
    // Extended 12/59 is the fake shift some keys wrap themselves in.
    if (key_v && !(ext_v && (rx_dat_i == SC_SHIFT_L ||
                             rx_dat_i == SC_SHIFT_R))) begin
      push_v = 1'b1;
      unique case (1'b1)
        rx_dat_i == SC_SHIFT_L:
          held_d[H_LSHIFT] = !brk_v;
        rx_dat_i == SC_SHIFT_R:
          held_d[H_RSHIFT] = !brk_v;
        rx_dat_i == SC_CTRL && !ext_v:
          held_d[H_LCTRL] = !brk_v;
        rx_dat_i == SC_CTRL && ext_v:
          held_d[H_RCTRL] = !brk_v;
        rx_dat_i == SC_ALT && !ext_v:
          held_d[H_LALT] = !brk_v;
        rx_dat_i == SC_ALT && ext_v:
          held_d[H_RALT] = !brk_v;
        rx_dat_i == SC_CAPS && !ext_v: begin
          tgl_v[2] = !brk_v && !held_q[H_CAPS];
          held_d[H_CAPS] = !brk_v;
        end
        rx_dat_i == SC_NUM && !ext_v: begin
          tgl_v[1] = !brk_v && !held_q[H_NUM];
          held_d[H_NUM] = !brk_v;
        end
        rx_dat_i == SC_SCRL && !ext_v: begin
          tgl_v[0] = !brk_v && !held_q[H_SCRL];
          held_d[H_SCRL] = !brk_v;
        end
        default: ;
      endcase
    end
`ifdef KBD_DEC_LOCK_EN
    lock_d = lock_q ^ tgl_v;
`endif
    ev_v.brk   = brk_v;
    ev_v.ext   = ext_v;
    ev_v.caps  = lock_d[2];
    ev_v.num   = lock_d[1];
    ev_v.alt   = held_d[H_LALT] | held_d[H_RALT];
    ev_v.ctrl  = held_d[H_LCTRL] | held_d[H_RCTRL];
    ev_v.shift = held_d[H_LSHIFT] | held_d[H_RSHIFT];
    ev_v.rsvd  = 1'b0;
    ev_v.code  = code_v;
  end

  always_comb begin
    ovf_d  = clr_i ? 1'b0 : (ovf_q | fifo_drop);
    perr_d = clr_i ? 1'b0 : (perr_q | (rx_stb_i & rx_perr_i));
    bat_d  = clr_i ? 1'b0 :
             (bat_q | (ok_stb & (rx_dat_i == SC_BAT)));
    ack_d  = fa_v;
  end

  ps2_evt_fifo #(
    .pDepth (pFifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_v),
    .dat_i   (ev_v),
    .pop_i   (ev_pop_i),
    .valid_o (ev_valid_o),
    .dat_o   (fifo_dat),
    .drop_o  (fifo_drop)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      held_q <= '0;
      lock_q <= '0;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      bat_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      held_q <= held_d;
      lock_q <= lock_d;
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
      bat_q  <= bat_d;
      ack_q  <= ack_d;
    end
  end

  assign ev_dat_o = fifo_dat;
  assign ovf_o    = ovf_q;
  assign perr_o   = perr_q;
  assign bat_o    = bat_q;
  assign ack_o    = ack_q;

`ifdef KBD_DEC_LOCK_EN
  led_st_e led_q, led_d;
  logic    pend_q, pend_d;
  logic    fe_v, tgl_any;

  assign fe_v    = ok_stb && (rx_dat_i == SC_RESEND);
  assign tgl_any = |tgl_v;

  always_comb begin
    led_d    = led_q;
    pend_d   = pend_q;
    tx_req_o = 1'b0;
    tx_dat_o = 8'h00;
    if (tgl_any && (led_q != L_IDLE))
      pend_d = 1'b1;
    unique case (led_q)
      L_IDLE: begin
        if (tgl_any || pend_q) begin
          led_d  = L_CMD;
          pend_d = 1'b0;
        end
      end
      L_CMD: begin
        tx_req_o = 1'b1;
        tx_dat_o = SC_LED;
        if (tx_done_i) led_d = L_WACK1;
      end
      L_WACK1: begin
        if (fa_v)      led_d = L_DATA;
        else if (fe_v) led_d = L_CMD;
      end
      L_DATA: begin
        tx_req_o = 1'b1;
        tx_dat_o = {5'b0, lock_q};
        if (tx_done_i) led_d = L_WACK2;
      end
      L_WACK2: begin
        if (fa_v)      led_d = L_IDLE;
        else if (fe_v) led_d = L_DATA;
      end
      default: led_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q  <= L_IDLE;
      pend_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      pend_q <= pend_d;
    end
  end
`else
  assign tx_req_o = 1'b0;
  assign tx_dat_o = 8'h00;
`endif

  assign unused_ok = ^{tx_done_i, lock_q[0], tgl_v};

endmodule
